// File: rtl/text_plane.sv
// Character-cell text plane: registered reads, hardware scroll, clear engine and cursor put port.
// Define TEXT_PLANE_AUTOSCROLL_EN to scroll on bottom-right overflow instead of wrapping to (0,0).
module text_plane #(
    parameter int unsigned ROWS   = 15,
    parameter int unsigned COLS   = 40,
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 6,
    parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              put_valid,
    output logic              put_ready,
    input  logic [CHAR_W-1:0] put_data,
    input  logic              cmd_clear,
    input  logic              cmd_scroll,
    output logic              busy,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  scroll_base
);

    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned ADDR_W = $clog2(CELLS);
    localparam logic [CHAR_W-1:0] NEWLINE = CHAR_W'(8'h0A);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_FILL
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic [ROW_W-1:0]    cur_row_q;
    logic [COL_W-1:0]    cur_col_q;
    logic [ROW_W-1:0]    base_q;
    logic [ADDR_W-1:0]   fill_addr_q;
    logic [ADDR_W-1:0]   fill_left_q;
    logic [CHAR_W-1:0]   rd_data_q;
    logic [CHAR_W-1:0]   mem_q [CELLS];

    logic [ROW_W-1:0]    cur_row_d;
    logic [COL_W-1:0]    cur_col_d;
    logic                adv_scroll;
    logic                idle;
    logic                accept_put;
    logic                rd_in_range;
    logic                wr_in_range;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   top_row_addr;
    logic [ROW_W-1:0]    base_inc;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CHAR_W-1:0]   mem_wdata;

    // Inputs are both < ROWS, so one conditional subtract gives the modulo.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                 input logic [ROW_W-1:0] base);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, base};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign idle        = (state_q == IDLE);
    assign accept_put  = idle && put_valid && !wr_valid;
    assign rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
    assign wr_in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign rd_addr     = cell_addr(phys_row(rd_row, base_q), rd_col);
    assign wr_addr     = cell_addr(phys_row(wr_row, base_q), wr_col);
    assign cur_addr    = cell_addr(phys_row(cur_row_q, base_q), cur_col_q);
    assign top_row_addr = cell_addr(base_q, '0);
    assign base_inc    = phys_row(ROW_W'(1), base_q);

    always_comb begin
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        adv_scroll = 1'b0;
        if (put_data != NEWLINE && 32'(cur_col_q) != COLS - 1) begin
            cur_col_d = cur_col_q + COL_W'(1);
        end else begin
            cur_col_d = '0;
            if (32'(cur_row_q) == ROWS - 1) begin
`ifdef TEXT_PLANE_AUTOSCROLL_EN
                adv_scroll = 1'b1;
`else
                cur_row_d = '0;
`endif
            end else begin
                cur_row_d = cur_row_q + ROW_W'(1);
            end
        end
    end

    // Single write port: absolute write beats put; fill engine owns the port when busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = FILL_CHAR;
        unique case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    mem_we    = wr_in_range;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else if (put_valid && put_data != NEWLINE) begin
                    mem_we    = 1'b1;
                    mem_addr  = cur_addr;
                    mem_wdata = put_data;
                end
            end
            CLEAR, SCROLL_FILL: begin
                mem_we   = 1'b1;
                mem_addr = fill_addr_q;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (!reset_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_in_range ? mem_q[rd_addr] : FILL_CHAR;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            base_q      <= '0;
            fill_addr_q <= '0;
            fill_left_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_put) begin
                        cur_row_q <= cur_row_d;
                        cur_col_q <= cur_col_d;
                    end
                    if (cmd_clear) begin
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        base_q      <= '0;
                        cur_row_q   <= '0;
                        cur_col_q   <= '0;
                        fill_addr_q <= '0;
                        fill_left_q <= ADDR_W'(CELLS - 1);
                    end else if (cmd_scroll || (accept_put && adv_scroll)) begin
                        state_q     <= SCROLL_FILL;
                        busy_q      <= 1'b1;
                        base_q      <= base_inc;
                        fill_addr_q <= top_row_addr;
                        fill_left_q <= ADDR_W'(COLS - 1);
                    end
                end
                CLEAR, SCROLL_FILL: begin
                    if (fill_left_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        fill_addr_q <= fill_addr_q + ADDR_W'(1);
                        fill_left_q <= fill_left_q - ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign wr_ready    = ~busy_q;
    assign put_ready   = ~busy_q & ~wr_valid;
    assign cursor_row  = cur_row_q;
    assign cursor_col  = cur_col_q;
    assign scroll_base = base_q;

endmodule

// File: tb/tb_text_plane.sv
// Self-checking bench for text_plane: cell-level reference model plus directed literal checks.
module tb_text_plane;

    localparam int ROWS  = 15;
    localparam int COLS  = 40;
    localparam int CELLS = ROWS * COLS;
    localparam logic [7:0] FILL = 8'h20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] rd_row = '0;
    logic [5:0] rd_col = '0;
    logic [7:0] rd_data;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_row = '0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic       put_valid = 1'b0;
    logic       put_ready;
    logic [7:0] put_data = '0;
    logic       cmd_clear = 1'b0;
    logic       cmd_scroll = 1'b0;
    logic       busy;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic [3:0] scroll_base;

    always #5 clock = ~clock;

    text_plane #(
        .ROWS(15), .COLS(40), .CHAR_W(8), .ROW_W(4), .COL_W(6), .FILL_CHAR(8'h20)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .put_valid(put_valid), .put_ready(put_ready), .put_data(put_data),
        .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .busy(busy),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .scroll_base(scroll_base)
    );

    int vecs = 0;
    int miss = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: cell array indexed by physical address, fill work as a queue of addresses.
    logic [7:0] m_mem [CELLS];
    bit         m_known [CELLS];
    int         m_base = 0;
    int         m_row = 0;
    int         m_col = 0;
    int         fillq [$];
    logic [7:0] m_rd = '0;
    bit         m_rd_known = 1'b1;

    function automatic int paddr(input int r, input int c);
        return ((r + m_base) % ROWS) * COLS + c;
    endfunction

    always @(posedge clock) begin : model
        int a;
        bit scroll;
        bit wrap;
        if (!reset_n) begin
            fillq.delete();
            m_base = 0;
            m_row = 0;
            m_col = 0;
            m_rd = '0;
            m_rd_known = 1'b1;
        end else begin
            if (int'(rd_row) >= ROWS || int'(rd_col) >= COLS) begin
                m_rd = FILL;
                m_rd_known = 1'b1;
            end else begin
                a = paddr(int'(rd_row), int'(rd_col));
                m_rd = m_mem[a];
                m_rd_known = m_known[a];
            end
            if (fillq.size() != 0) begin
                a = fillq.pop_front();
                m_mem[a] = FILL;
                m_known[a] = 1'b1;
            end else begin
                scroll = cmd_scroll;
                if (wr_valid) begin
                    if (int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
                        a = paddr(int'(wr_row), int'(wr_col));
                        m_mem[a] = wr_data;
                        m_known[a] = 1'b1;
                    end
                end else if (put_valid) begin
                    wrap = 1'b1;
                    if (put_data != 8'h0A) begin
                        a = paddr(m_row, m_col);
                        m_mem[a] = put_data;
                        m_known[a] = 1'b1;
                        wrap = (m_col == COLS - 1);
                        if (!wrap) m_col++;
                    end
                    if (wrap) begin
                        m_col = 0;
                        if (m_row == ROWS - 1) begin
`ifdef TEXT_PLANE_AUTOSCROLL_EN
                            scroll = 1'b1;
`else
                            m_row = 0;
`endif
                        end else begin
                            m_row++;
                        end
                    end
                end
                if (cmd_clear) begin
                    m_base = 0;
                    m_row = 0;
                    m_col = 0;
                    for (int i = 0; i < CELLS; i++) fillq.push_back(i);
                end else if (scroll) begin
                    for (int c = 0; c < COLS; c++) fillq.push_back(m_base * COLS + c);
                    m_base = (m_base + 1) % ROWS;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            if (m_rd_known) chk("rd_data", int'(rd_data), int'(m_rd));
            chk("busy", int'(busy), int'(fillq.size() != 0));
            chk("wr_ready", int'(wr_ready), int'(fillq.size() == 0));
            chk("put_ready", int'(put_ready), int'(fillq.size() == 0 && !wr_valid));
            chk("cursor_row", int'(cursor_row), m_row);
            chk("cursor_col", int'(cursor_col), m_col);
            chk("scroll_base", int'(scroll_base), m_base);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_chk(input string name, input int r, input int c, input int exp);
        rd_row = 4'(r);
        rd_col = 6'(c);
        tick();
        chk(name, int'(rd_data), exp);
    endtask

    task automatic wr(input int r, input int c, input int d);
        chk("wr_ready_before_write", int'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_row = 4'(r);
        wr_col = 6'(c);
        wr_data = 8'(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic put_char(input int d);
        int n;
        bit acc;
        put_valid = 1'b1;
        put_data = 8'(d);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = put_ready;
            tick();
            n++;
        end
        put_valid = 1'b0;
        if (!acc) chk("put_timeout", 0, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    int n;
    int exp_base;

    initial begin
        tick();
        checking = 1'b1;
        tick();
        tick();
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cursor_row", int'(cursor_row), 0);
        chk("reset_cursor_col", int'(cursor_col), 0);
        chk("reset_scroll_base", int'(scroll_base), 0);
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_put_ready", int'(put_ready), 1);
        reset_n = 1'b1;
        tick();

        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        wait_idle(n);
        chk("clear_busy_cycles", n, 600);
        read_chk("clear_cell_14_39", 14, 39, 8'h20);
        chk("clear_cursor_row", int'(cursor_row), 0);
        chk("clear_scroll_base", int'(scroll_base), 0);

        wr(3, 5, 8'h41);
        read_chk("wr_3_5", 3, 5, 8'h41);
        read_chk("oob_row_read", 15, 0, 8'h20);
        read_chk("oob_col_read", 2, 63, 8'h20);
        wr(0, 40, 8'h42);
        read_chk("oob_write_no_alias", 1, 0, 8'h20);
        read_chk("oob_write_0_39", 0, 39, 8'h20);

        put_char(8'h41);
        put_char(8'h42);
        put_char(8'h0A);
        put_char(8'h43);
        read_chk("put_0_0", 0, 0, 8'h41);
        read_chk("put_0_1", 0, 1, 8'h42);
        read_chk("put_1_0", 1, 0, 8'h43);
        chk("put_cursor_row", int'(cursor_row), 1);
        chk("put_cursor_col", int'(cursor_col), 1);

        wr_valid = 1'b1;
        wr_row = 4'd5;
        wr_col = 6'd5;
        wr_data = 8'h77;
        put_valid = 1'b1;
        put_data = 8'h44;
        #1;
        chk("put_blocked_by_wr", int'(put_ready), 0);
        tick();
        wr_valid = 1'b0;
        put_valid = 1'b0;
        chk("put_not_taken_col", int'(cursor_col), 1);
        put_char(8'h44);
        chk("put_retry_col", int'(cursor_col), 2);
        read_chk("put_retry_cell", 1, 1, 8'h44);
        read_chk("wr_wins_cell", 5, 5, 8'h77);

        for (int i = 0; i < 13; i++) put_char(8'h0A);
        for (int i = 0; i < 39; i++) put_char(8'h78);
        chk("pre_wrap_row", int'(cursor_row), 14);
        chk("pre_wrap_col", int'(cursor_col), 39);
        put_char(8'h5A);
`ifdef TEXT_PLANE_AUTOSCROLL_EN
        chk("auto_cursor_row", int'(cursor_row), 14);
        chk("auto_cursor_col", int'(cursor_col), 0);
        chk("auto_scroll_base", int'(scroll_base), 1);
        wait_idle(n);
        chk("auto_busy_cycles", n, 40);
        read_chk("auto_old_bottom", 13, 39, 8'h5A);
        for (int c = 0; c < COLS; c++) read_chk("auto_new_bottom", 14, c, 8'h20);
        exp_base = 2;
`else
        chk("wrap_cursor_row", int'(cursor_row), 0);
        chk("wrap_cursor_col", int'(cursor_col), 0);
        chk("wrap_busy", int'(busy), 0);
        chk("wrap_scroll_base", int'(scroll_base), 0);
        read_chk("wrap_cell_14_39", 14, 39, 8'h5A);
        exp_base = 1;
`endif
        cmd_scroll = 1'b1;
        tick();
        cmd_scroll = 1'b0;
        wait_idle(n);
        chk("scroll_busy_cycles", n, 40);
        chk("scroll_base_after_cmd", int'(scroll_base), exp_base);
        for (int c = 0; c < COLS; c += 13) read_chk("scroll_bottom_fill", 14, c, 8'h20);

        cmd_clear = 1'b1;
        cmd_scroll = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            cmd_scroll = (n == 10);
            tick();
            cmd_scroll = 1'b0;
            n++;
        end
        chk("clear_wins_busy_cycles", n, 600);
        chk("clear_wins_scroll_base", int'(scroll_base), 0);

        wr(0, 0, 8'h55);
        wr(1, 10, 8'h56);
        wr(2, 39, 8'h66);
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_ready", int'(wr_ready), 1);
        chk("abort_cursor_row", int'(cursor_row), 0);
        chk("abort_cursor_col", int'(cursor_col), 0);
        for (int a = 0; a < 100; a++) read_chk("abort_filled", a / COLS, a % COLS, 8'h20);
        read_chk("abort_unfilled", 2, 39, 8'h66);

        tick();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/text_plane.md
# text_plane

Parametrised character-cell memory for the text-mode display path, with registered reads, hardware scrolling, a screen-clear engine and a cursor-driven "put" port with auto-advance. The video scan-out side reads through `rd_*`. The CPU/console side writes either by absolute cell address (`wr_*`) or by streaming characters at the cursor (`put_*`). One memory of ROWS×COLS cells of CHAR_W bits, inferred as block RAM.

## Interface
- ROWS, 15, number of text lines
- COLS, 40, characters per line
- CHAR_W, 8, character id width
- ROW_W, 4, row index width, ≥ ceil(log2(ROWS))
- COL_W, 6, column index width, ≥ ceil(log2(COLS))
- FILL_CHAR, 8'h20, value written by clear/scroll fill; also returned for out-of-range reads
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- rd_row / rd_col  in  ROW_W / COL_W  logical read cell
- rd_data  out  CHAR_W  read data, registered
- wr_valid  in  1  absolute write request
- wr_ready  out  1  absolute write accepted when valid&ready
- wr_row / wr_col / wr_data  in  ROW_W / COL_W / CHAR_W  logical cell and character
- put_valid  in  1  cursor write request
- put_ready  out  1  cursor write accepted when valid&ready
- put_data  in  CHAR_W  character; 8'h0A is newline
- cmd_clear  in  1  single-cycle pulse: fill screen, home cursor
- cmd_scroll  in  1  single-cycle pulse: scroll up one line
- busy  out  1  clear/scroll fill in progress
- cursor_row / cursor_col  out  ROW_W / COL_W  current cursor (logical)
- scroll_base  out  ROW_W  physical row shown as logical row 0

## Operation
- Logical→physical: prow = (lrow + scroll_base) mod ROWS; address = prow*COLS + col. The modulo uses a compare-and-subtract, never a divider.
- Out-of-range handling: a logical row ≥ ROWS or a col ≥ COLS is out of range.
  - Out-of-range read: rd_data = FILL_CHAR.
  - Out-of-range wr: the handshake completes and memory is unchanged.
- FSM states: IDLE, CLEAR, SCROLL_FILL.
- IDLE:
  - wr_ready = 1.
  - put_ready = ~wr_valid. An absolute write wins over put in the same cycle.
- Absolute write: writes memory only. The cursor is unaffected.
- Put, non-newline:
  - Write put_data at the cursor, then advance col.
  - When col = COLS-1: col → 0 and row → row+1.
  - When row = ROWS-1 and the line wraps: see Configuration.
- Put, 8'h0A: nothing is written. col → 0, row advances with the same wrap rule.
- cmd_clear in IDLE:
  - Go to CLEAR.
  - scroll_base → 0, cursor → (0,0).
  - Write FILL_CHAR to physical addresses 0..ROWS*COLS-1, one per cycle.
  - Return to IDLE.
- cmd_scroll in IDLE, or an auto-scroll:
  - scroll_base → (scroll_base+1) mod ROWS.
  - Go to SCROLL_FILL and write FILL_CHAR to the new logical row ROWS-1 (the old physical top row), cols 0..COLS-1.
  - The cursor row is unchanged.
- cmd_clear and cmd_scroll in the same cycle: clear wins and the scroll is dropped.
- CLEAR / SCROLL_FILL: busy = 1, wr_ready = put_ready = 0. cmd_clear/cmd_scroll are ignored (not queued).
- Reads are never stalled.
- Read of a cell written on the same edge returns the old data.

## Timing
- Reset values (reset_n low at an edge):
  - rd_data = 0, busy = 0.
  - cursor = (0,0), scroll_base = 0.
  - State IDLE, so wr_ready = 1 and put_ready = ~wr_valid.
  - Memory contents are not reset.
- Read latency: 1 cycle. rd_row/rd_col sampled at edge N → rd_data valid after edge N.
- Write/put: the accepting edge writes memory and updates cursor/scroll_base on the same edge.
- CLEAR: busy is high for exactly ROWS*COLS cycles, starting the edge after the cmd_clear sample. wr_ready returns 1 the cycle after the last fill write.
- SCROLL_FILL: busy is high for exactly COLS cycles. scroll_base updates on the entering edge.
- reset_n low mid-fill: abort immediately into IDLE with reset values. Partially filled cells keep whatever was written.

## Configuration
- TEXT_PLANE_AUTOSCROLL_EN defined: a put or newline that would advance past (ROWS-1, COLS-1), or a newline on row ROWS-1, does the following:
  - Set the cursor to (ROWS-1, 0).
  - Trigger a scroll (SCROLL_FILL, COLS busy cycles) on the accepting edge.
- TEXT_PLANE_AUTOSCROLL_EN undefined: the cursor wraps to (0,0). There is no scroll and no busy period. cmd_scroll still works.

## Test plan
- Reset, then cmd_clear; wait busy low (600 cycles at defaults); read (14,39) → 8'h20; cursor (0,0); scroll_base 0.
- wr (3,5,8'h41); next cycle read (3,5) → after 1 cycle rd_data 8'h41; read (15,0) → 8'h20; wr (0,40,8'h42) → accepted, no cell changed.
- Put "AB",8'h0A,"C" from (0,0) → (0,0)=41, (0,1)=42, (1,0)=43; cursor (1,1). Assert wr_valid with put_valid → put_ready 0 that cycle, put retried next.
- AUTOSCROLL_EN: cursor at (14,39), put 8'h5A → (14,39)=5A before scroll; scroll_base 1; busy 40 cycles; logical (14,0..39) = 8'h20; old logical (14,39) now read at (13,39)=5A; cursor (14,0).
- cmd_clear and cmd_scroll same cycle → only clear (600 busy cycles, scroll_base 0). cmd_scroll during busy → ignored.
- reset_n low at cycle 100 of CLEAR → busy 0 next cycle, wr_ready 1, cursor (0,0); the first 100 cells read 8'h20.
